// File: rtl/boid_pkg.sv
// Shared display geometry and frame-writer FSM encoding.
package boid_pkg;

  localparam int unsigned H_RES       = 640;
  localparam int unsigned V_RES       = 480;
  localparam int unsigned PIXEL_COUNT = H_RES * V_RES;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    LATCH,
    DRAW,
    FINISH
  } state_e;

endpackage

// File: rtl/boid_pixel_addr.sv
// Converts a sprite pixel (x+dx, y+dy) into a linear pixel address and flags
// pixels that fall off the visible area.
module boid_pixel_addr #(
  parameter int unsigned H_RES      = boid_pkg::H_RES,
  parameter int unsigned V_RES      = boid_pkg::V_RES,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic [9:0]            x,
  input  logic [8:0]            y,
  input  logic [1:0]            dx,
  input  logic [1:0]            dy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_bounds
);

  logic [10:0]           px;
  logic [9:0]            py;
  logic [ADDR_WIDTH-1:0] py_w;

  assign px        = {1'b0, x} + {9'b0, dx};
  assign py        = {1'b0, y} + {8'b0, dy};
  assign py_w      = ADDR_WIDTH'(py);
  assign in_bounds = (px < 11'(H_RES)) && (py < 10'(V_RES));

  // Row stride of 640 = 512 + 128, so the multiply becomes two shifts.
  assign addr = (py_w << 9) + (py_w << 7) + ADDR_WIDTH'(px);

endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame sprite updater: erases every boid at its previous position, then
// latches and draws each active boid into a 1-bit pixel memory.
module boid_frame_writer #(
  parameter  int unsigned MAX_BOIDS  = 8,
  parameter  int unsigned BOID_SIZE  = 2,
  parameter  int unsigned H_RES      = boid_pkg::H_RES,
  parameter  int unsigned V_RES      = boid_pkg::V_RES,
  parameter  int unsigned ADDR_WIDTH = 19,
  localparam int unsigned BOID_BITS  = $clog2(MAX_BOIDS)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  frame_start,
  input  logic [BOID_BITS:0]    num_boids,
  output logic [BOID_BITS-1:0]  boid_sel,
  input  logic [9:0]            boid_x,
  input  logic [8:0]            boid_y,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            overrun_cnt
);

  localparam logic [1:0]         LAST_D = 2'(BOID_SIZE - 1);
  localparam logic [BOID_BITS:0] MAX_N  = (BOID_BITS + 1)'(MAX_BOIDS);
  localparam logic [BOID_BITS:0] ONE_N  = (BOID_BITS + 1)'(1);

  boid_pkg::state_e      state_q, state_d;
  logic [BOID_BITS-1:0]  idx_q, idx_d;
  logic [1:0]            dx_q, dx_d, dy_q, dy_d;
  logic [BOID_BITS:0]    n_q, n_d, prev_n_q, prev_n_d;
  logic [7:0]            ovr_q, ovr_d;
  logic                  wr_en_q, wr_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  logic [9:0]            prev_x [MAX_BOIDS];
  logic [8:0]            prev_y [MAX_BOIDS];

  logic [ADDR_WIDTH-1:0] pix_addr;
  logic                  pix_in;
  logic                  pix_cycle, last_pix, last_erase, last_draw;

  // DRAW reads back the slot LATCH just wrote, so one lookup serves both phases.
  boid_pixel_addr #(
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pixel_addr (
    .x        (prev_x[idx_q]),
    .y        (prev_y[idx_q]),
    .dx       (dx_q),
    .dy       (dy_q),
    .addr     (pix_addr),
    .in_bounds(pix_in)
  );

  assign pix_cycle  = (state_q == boid_pkg::ERASE) || (state_q == boid_pkg::DRAW);
  assign last_pix   = (dx_q == LAST_D) && (dy_q == LAST_D);
  assign last_erase = ({1'b0, idx_q} == (prev_n_q - ONE_N));
  assign last_draw  = ({1'b0, idx_q} == (n_q - ONE_N));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    n_d      = n_q;
    prev_n_d = prev_n_q;
    ovr_d    = ovr_q;

    if (frame_start && (state_q != boid_pkg::IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    // Row-major walk over the sprite; wraps to (0,0) on its last pixel.
    if (pix_cycle) begin
      if (dx_q == LAST_D) begin
        dx_d = '0;
        dy_d = dy_q + 2'd1;
      end else begin
        dx_d = dx_q + 2'd1;
      end
      if (last_pix) dy_d = '0;
    end

    case (state_q)
      boid_pkg::IDLE: begin
        if (frame_start) begin
          n_d   = (num_boids > MAX_N) ? MAX_N : num_boids;
          idx_d = '0;
          dx_d  = '0;
          dy_d  = '0;
          if (prev_n_q != '0)  state_d = boid_pkg::ERASE;
          else if (n_d != '0)  state_d = boid_pkg::LATCH;
          else                 state_d = boid_pkg::FINISH;
        end
      end
      boid_pkg::ERASE: begin
        if (last_pix) begin
          if (last_erase) begin
            idx_d   = '0;
            state_d = (n_q != '0) ? boid_pkg::LATCH : boid_pkg::FINISH;
          end else begin
            idx_d = idx_q + BOID_BITS'(1);
          end
        end
      end
      boid_pkg::LATCH: state_d = boid_pkg::DRAW;
      boid_pkg::DRAW: begin
        if (last_pix) begin
          if (last_draw) begin
            state_d = boid_pkg::FINISH;
          end else begin
            idx_d   = idx_q + BOID_BITS'(1);
            state_d = boid_pkg::LATCH;
          end
        end
      end
      boid_pkg::FINISH: begin
        prev_n_d = n_q;
        state_d  = boid_pkg::IDLE;
      end
      default: state_d = boid_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= boid_pkg::IDLE;
      idx_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      n_q       <= '0;
      prev_n_q  <= '0;
      ovr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      n_q       <= n_d;
      prev_n_q  <= prev_n_d;
      ovr_q     <= ovr_d;
      wr_en_q   <= pix_cycle && pix_in;
      wr_data_q <= (state_q == boid_pkg::DRAW);
      if (pix_cycle) wr_addr_q <= pix_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == boid_pkg::LATCH) begin
      prev_x[idx_q] <= boid_x;
      prev_y[idx_q] <= boid_y;
    end
  end

  assign boid_sel    = (state_q == boid_pkg::LATCH) ? idx_q : '0;
  assign busy        = (state_q != boid_pkg::IDLE);
  assign done        = (state_q == boid_pkg::FINISH);
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_boid_frame_writer.sv
// Scoreboard bench for boid_frame_writer: expected pixel writes are queued by
// the stimulus, and a negedge monitor pops and compares every wr_en cycle.
module tb_boid_frame_writer;

  localparam int unsigned MAX_BOIDS = 8;
  localparam int unsigned BB        = $clog2(MAX_BOIDS);

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          frame_start = 1'b0;
  logic [BB:0]   num_boids = '0;
  logic [BB-1:0] boid_sel;
  logic [9:0]    boid_x;
  logic [8:0]    boid_y;
  logic          wr_en, wr_data, busy, done;
  logic [18:0]   wr_addr;
  logic [7:0]    overrun_cnt;

  logic [9:0]    bx [MAX_BOIDS];
  logic [8:0]    by [MAX_BOIDS];

  typedef struct packed {
    logic [18:0] addr;
    logic        data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  always #5 clock = ~clock;

  boid_frame_writer #(
    .MAX_BOIDS (8),
    .BOID_SIZE (2),
    .H_RES     (640),
    .V_RES     (480),
    .ADDR_WIDTH(19)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .frame_start(frame_start),
    .num_boids  (num_boids),
    .boid_sel   (boid_sel),
    .boid_x     (boid_x),
    .boid_y     (boid_y),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .overrun_cnt(overrun_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int addr, input bit data);
    wr_t e;
    e.addr = addr[18:0];
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic push_sprite(input int x, input int y, input bit data);
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        if ((x + dx) < 640 && (y + dy) < 480) push((y + dy) * 640 + x + dx, data);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " wr_en"}, wr_en, 0);
    chk({tag, " wr_addr"}, wr_addr, 0);
    chk({tag, " wr_data"}, wr_data, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " boid_sel"}, boid_sel, 0);
    chk({tag, " overrun_cnt"}, overrun_cnt, 0);
  endtask

  // Cycle 1 is the frame_start cycle; the reported length is the cycle index of done.
  task automatic run_frame(input int n, input int exp_len, input int ovr_at,
                           input int rst_at, input string name);
    int cyc;
    bit seen;
    @(posedge clock); #1;
    num_boids   = n[BB:0];
    frame_start = 1'b1;
    @(posedge clock); #1;
    cyc  = 2;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      frame_start = (cyc == ovr_at);
      if (cyc == rst_at) begin
        frame_start = 1'b0;
        resetn      = 1'b0;
        return;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock); #1;
      cyc++;
    end
    frame_start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s done: not seen within 300 cycles, expected at cycle %0d", name, exp_len);
    end else begin
      chk({name, " frame length"}, cyc, exp_len);
    end
    @(posedge clock); #1;
    chk({name, " busy after done"}, busy, 0);
    chk({name, " done width"}, done, 0);
    chk({name, " writes outstanding"}, sb.size(), 0);
  endtask

  always @(negedge clock) begin
    if (resetn && wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected write: addr %0d data %0d, expected none", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MAX_BOIDS; i++) begin
      bx[i] = '0;
      by[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    check_idle_zero("reset");
    resetn = 1'b1;

    bx[0] = 10'd10; by[0] = 9'd10;
    push(6410, 1); push(6411, 1); push(7050, 1); push(7051, 1);
    run_frame(1, 7, 0, 0, "first draw");

    bx[0] = 10'd11;
    push(6410, 0); push(6411, 0); push(7050, 0); push(7051, 0);
    push(6411, 1); push(6412, 1); push(7051, 1); push(7052, 1);
    run_frame(1, 11, 0, 0, "move right");

    push(6411, 0); push(6412, 0); push(7051, 0); push(7052, 0);
    run_frame(0, 6, 0, 0, "erase only");

    run_frame(0, 2, 0, 0, "empty frame");

    bx[0] = 10'd639; by[0] = 9'd479;
    push(307199, 1);
    run_frame(1, 7, 0, 0, "corner clip");

    push(307199, 0);
    for (int i = 0; i < MAX_BOIDS; i++) begin
      bx[i] = 10'(100 + 10 * i);
      by[i] = 9'd50;
      push_sprite(100 + 10 * i, 50, 1);
    end
    run_frame(8, 46, 4, 0, "full with overrun");
    chk("overrun_cnt", overrun_cnt, 1);

    for (int i = 0; i < MAX_BOIDS; i++) push_sprite(100 + 10 * i, 50, 0);
    bx[0] = 10'd20; by[0] = 9'd20;
    run_frame(1, 0, 0, 36, "reset in draw");
    repeat (2) @(posedge clock);
    #1;
    check_idle_zero("mid-frame reset");
    chk("erase writes before reset", sb.size(), 0);
    sb.delete();
    resetn = 1'b1;

    push(12820, 1); push(12821, 1); push(13460, 1); push(13461, 1);
    run_frame(1, 7, 0, 0, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
